// File: rtl/async_fifo_wr_ctrl.sv
// rtl/async_fifo_wr_ctrl.sv - write-domain pointer, synchroniser, full and level control for the async FIFO
// Optional almost-full flag is built only when FIFO_ALMOST_FULL_EN is defined.
module async_fifo_wr_ctrl #(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AF_THRESH   = (1 << ADDR_WIDTH) - 2
) (
   input  logic                  W_CLK,
   input  logic                  W_RST,
   input  logic                  W_INC,
   input  logic [ADDR_WIDTH:0]   R_Gray_Ptr,
   output logic                  W_CLK_en,
   output logic [ADDR_WIDTH-1:0] W_Addr,
   output logic [ADDR_WIDTH:0]   W_Gray_Ptr,
   output logic                  W_Full,
   output logic [ADDR_WIDTH:0]   W_Level,
   output logic                  W_Almost_Full
);

   localparam int A = ADDR_WIDTH;

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("SYNC_STAGES must be at least 2");
      end
      if (ADDR_WIDTH < 2) begin : g_bad_addr
         $error("ADDR_WIDTH must be at least 2");
      end
   endgenerate

   function automatic logic [A:0] gray2bin(input logic [A:0] g);
      logic [A:0] b;
      b[A] = g[A];
      for (int i = A - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [A:0] wbin;
   logic [A:0] wgray;
   logic [A:0] wbin_next;
   logic [A:0] wgray_next;
   logic [A:0] sync_q [SYNC_STAGES];
   logic [A:0] rq_sync;
   logic [A:0] rbin_sync;
   logic       push;
   logic       full_next;

   // Reset gates the enable so no RAM write can slip through while W_RST is low.
   assign push       = W_INC & ~W_Full & W_RST;
   assign wbin_next  = wbin + {{A{1'b0}}, push};
   assign wgray_next = (wbin_next >> 1) ^ wbin_next;
   assign rq_sync    = sync_q[SYNC_STAGES-1];
   assign rbin_sync  = gray2bin(rq_sync);
   assign full_next  = (wgray_next == {~rq_sync[A:A-1], rq_sync[A-2:0]});

   assign W_CLK_en   = push;
   assign W_Addr     = wbin[A-1:0];
   assign W_Gray_Ptr = wgray;
   assign W_Level    = wbin - rbin_sync;

   always_ff @(posedge W_CLK or negedge W_RST) begin
      if (!W_RST) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= R_Gray_Ptr;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   always_ff @(posedge W_CLK or negedge W_RST) begin
      if (!W_RST) begin
         wbin   <= '0;
         wgray  <= '0;
         W_Full <= 1'b0;
      end else begin
         wbin   <= wbin_next;
         wgray  <= wgray_next;
         W_Full <= full_next;
      end
   end

`ifdef FIFO_ALMOST_FULL_EN
   logic [A:0] level_next;

   assign level_next = wbin_next - rbin_sync;

   always_ff @(posedge W_CLK or negedge W_RST) begin
      if (!W_RST) begin
         W_Almost_Full <= 1'b0;
      end else begin
         W_Almost_Full <= (int'(level_next) >= AF_THRESH);
      end
   end
`else
   generate
      if (AF_THRESH < 0) begin : g_af_unused
      end
   endgenerate

   assign W_Almost_Full = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb/tb_async_fifo_wr_ctrl.sv - randomized self-checking bench for async_fifo_wr_ctrl against a count-based model
module tb_async_fifo_wr_ctrl;

   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int MOD   = 2 * DEPTH;
   localparam int AF    = DEPTH - 2;

   logic          W_CLK = 1'b0;
   logic          W_RST = 1'b0;
   logic          W_INC = 1'b0;
   logic [AW:0]   R_Gray_Ptr = '0;
   logic          W_CLK_en;
   logic [AW-1:0] W_Addr;
   logic [AW:0]   W_Gray_Ptr;
   logic          W_Full;
   logic [AW:0]   W_Level;
   logic          W_Almost_Full;

   int checks = 0;
   int errors = 0;

   // Model: total writes accepted (mod 2*DEPTH) and the read counts driven at each edge.
   int m_w    = 0;
   int m_full = 0;
   int m_af   = 0;
   int hist[$];

   always #5 W_CLK = ~W_CLK;

   async_fifo_wr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .AF_THRESH(AF)) dut (
      .W_CLK(W_CLK), .W_RST(W_RST), .W_INC(W_INC), .R_Gray_Ptr(R_Gray_Ptr),
      .W_CLK_en(W_CLK_en), .W_Addr(W_Addr), .W_Gray_Ptr(W_Gray_Ptr),
      .W_Full(W_Full), .W_Level(W_Level), .W_Almost_Full(W_Almost_Full)
   );

   function automatic logic [AW:0] to_gray(input int b);
      logic [AW:0] v;
      v = b[AW:0];
      return v ^ (v >> 1);
   endfunction

   function automatic int seen_read();
      return (hist.size() >= 2) ? hist[hist.size()-2] : 0;
   endfunction

   // Called just after a negedge; leaves the bench just after the following negedge.
   task automatic cycle(input logic inc, input int rcnt);
      int push;
      int old_rq;
      int new_rq;
      int exp_af;
      W_INC = inc;
      R_Gray_Ptr = to_gray(rcnt);
      #1;
      push = (inc && m_full == 0) ? 1 : 0;
      checks++;
      if (W_CLK_en !== push[0]) begin
         errors++;
         $display("FAIL wr_en got %0b want %0b", W_CLK_en, push[0]);
      end
      checks++;
      if (int'(W_Addr) !== m_w % DEPTH) begin
         errors++;
         $display("FAIL wr_addr got %0d want %0d", W_Addr, m_w % DEPTH);
      end
      @(posedge W_CLK);
      old_rq = seen_read();
      m_w = (m_w + push) % MOD;
      hist.push_back(rcnt % MOD);
      if (hist.size() > 4) void'(hist.pop_front());
      new_rq = seen_read();
      m_full = (((m_w - old_rq + MOD) % MOD) == DEPTH) ? 1 : 0;
      m_af = (((m_w - old_rq + MOD) % MOD) >= AF) ? 1 : 0;
      @(negedge W_CLK);
      #1;
      checks++;
      if (W_Gray_Ptr !== to_gray(m_w)) begin
         errors++;
         $display("FAIL wr_gray got %b want %b", W_Gray_Ptr, to_gray(m_w));
      end
      checks++;
      if (W_Full !== m_full[0]) begin
         errors++;
         $display("FAIL full got %0b want %0b", W_Full, m_full[0]);
      end
      checks++;
      if (int'(W_Level) !== (m_w - new_rq + MOD) % MOD) begin
         errors++;
         $display("FAIL level got %0d want %0d", W_Level, (m_w - new_rq + MOD) % MOD);
      end
`ifdef FIFO_ALMOST_FULL_EN
      exp_af = m_af;
`else
      exp_af = 0;
`endif
      checks++;
      if (W_Almost_Full !== exp_af[0]) begin
         errors++;
         $display("FAIL almost_full got %0b want %0b", W_Almost_Full, exp_af[0]);
      end
   endtask

   task automatic apply_reset();
      W_RST = 1'b0;
      W_INC = 1'b0;
      R_Gray_Ptr = '0;
      repeat (2) @(negedge W_CLK);
      W_RST = 1'b1;
      m_w = 0;
      m_full = 0;
      m_af = 0;
      hist.delete();
   endtask

   task automatic test_reset();
      apply_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 0);
      W_INC = 1'b1;
      #2;
      W_RST = 1'b0;
      #1;
      checks++;
      if (W_Addr !== '0 || W_Gray_Ptr !== '0 || W_Full !== 1'b0 || W_Level !== '0 || W_CLK_en !== 1'b0
          || W_Almost_Full !== 1'b0) begin
         errors++;
         $display("FAIL reset_async got addr=%0d gray=%b full=%0b level=%0d en=%0b af=%0b want all zero",
                  W_Addr, W_Gray_Ptr, W_Full, W_Level, W_CLK_en, W_Almost_Full);
      end
      @(posedge W_CLK);
      #1;
      checks++;
      if (W_Addr !== '0 || W_CLK_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold got addr=%0d en=%0b want 0 0", W_Addr, W_CLK_en);
      end
      @(negedge W_CLK);
      apply_reset();
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (int'(W_Addr) !== i) begin
            errors++;
            $display("FAIL fill_addr got %0d want %0d", W_Addr, i);
         end
         cycle(1'b1, 0);
      end
      checks++;
      if (W_Full !== 1'b1 || W_Gray_Ptr !== 5'b11000 || W_Level !== 5'd16) begin
         errors++;
         $display("FAIL fill_end got full=%0b gray=%b level=%0d want 1 11000 16", W_Full, W_Gray_Ptr, W_Level);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 3; i++) cycle(1'b1, 0);
      checks++;
      if (W_Addr !== '0 || W_Gray_Ptr !== 5'b11000 || W_Full !== 1'b1) begin
         errors++;
         $display("FAIL overflow_hold got addr=%0d gray=%b full=%0b want 0 11000 1", W_Addr, W_Gray_Ptr, W_Full);
      end
   endtask

   task automatic test_drain_one();
      cycle(1'b0, 1);
      cycle(1'b0, 1);
      checks++;
      if (W_Level !== 5'd15 || W_Full !== 1'b1) begin
         errors++;
         $display("FAIL drain_edge2 got level=%0d full=%0b want 15 1", W_Level, W_Full);
      end
      cycle(1'b0, 1);
      checks++;
      if (W_Full !== 1'b0) begin
         errors++;
         $display("FAIL drain_edge3 got full=%0b want 0", W_Full);
      end
   endtask

   task automatic test_wrap();
      int fulls;
      int tot;
      fulls = 0;
      apply_reset();
      for (int i = 0; i < 32; i++) begin
         tot = i;
         cycle(1'b1, (tot >= 4) ? tot - 4 : 0);
         if (W_Full) fulls++;
         if (i == 30) begin
            checks++;
            if (W_Gray_Ptr !== 5'b10000) begin
               errors++;
               $display("FAIL wrap_gray31 got %b want 10000", W_Gray_Ptr);
            end
         end
      end
      checks++;
      if (W_Gray_Ptr !== 5'b00000 || W_Addr !== 4'd0 || fulls != 0) begin
         errors++;
         $display("FAIL wrap_end got gray=%b addr=%0d fulls=%0d want 00000 0 0", W_Gray_Ptr, W_Addr, fulls);
      end
   endtask

   task automatic test_almost_full();
      logic exp;
      apply_reset();
      for (int i = 0; i < AF; i++) cycle(1'b1, 0);
`ifdef FIFO_ALMOST_FULL_EN
      exp = 1'b1;
`else
      exp = 1'b0;
`endif
      checks++;
      if (W_Almost_Full !== exp) begin
         errors++;
         $display("FAIL af_thresh got %0b want %0b", W_Almost_Full, exp);
      end
   endtask

   task automatic test_random();
      int rcnt;
      logic inc;
      apply_reset();
      rcnt = 0;
      for (int i = 0; i < 400; i++) begin
         inc = ($urandom_range(0, 3) != 0);
         // Reader runs in bursts so the FIFO both fills and drains.
         if (((i / 40) % 2) == 1 && rcnt != m_w && $urandom_range(0, 1) == 1) rcnt = (rcnt + 1) % MOD;
         cycle(inc, rcnt);
      end
   endtask

   initial begin
      @(negedge W_CLK);
      test_reset();
      test_fill();
      test_overflow();
      test_drain_one();
      test_wrap();
      test_almost_full();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
